// File: rtl/race_pkg.sv
// Shared race definitions: game-state codes seen by both physics engines, winner codes,
// and small helpers used by the race sequencer.
package race_pkg;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_CNT3   = 3'd1,
    ST_CNT2   = 3'd2,
    ST_CNT1   = 3'd3,
    ST_RACE   = 3'd4,
    ST_FINISH = 3'd5
  } race_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] x0, input logic [9:0] x1,
                                  input logic [9:0] y0, input logic [9:0] y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  function automatic race_state_e next_count_state(input race_state_e s);
    case (s)
      ST_CNT3: return ST_CNT2;
      ST_CNT2: return ST_CNT1;
      default: return ST_RACE;
    endcase
  endfunction

endpackage

// File: rtl/race_controller_lap_tracker.sv
// Per-player lap counter: a lap is credited when the car reaches the finish line after
// having visited the checkpoint since the last credited lap.
module lap_tracker
  import race_pkg::*;
#(
  parameter int unsigned LAPS  = 3,
  parameter logic [9:0]  FL_X0 = 10'd0,
  parameter logic [9:0]  FL_X1 = 10'd20,
  parameter logic [9:0]  FL_Y0 = 10'd100,
  parameter logic [9:0]  FL_Y1 = 10'd140,
  parameter logic [9:0]  CP_X0 = 10'd280,
  parameter logic [9:0]  CP_X1 = 10'd320,
  parameter logic [9:0]  CP_Y0 = 10'd100,
  parameter logic [9:0]  CP_Y1 = 10'd140
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [3:0] lap,
  output logic [3:0] lap_next
);

  localparam logic [3:0] LapMax = 4'(LAPS);

  logic in_cp, in_fl;
  logic cp_seen_q, cp_seen_d;
  logic [3:0] lap_q;

  assign in_cp = in_box(x, y, CP_X0, CP_X1, CP_Y0, CP_Y1);
  assign in_fl = in_box(x, y, FL_X0, FL_X1, FL_Y0, FL_Y1);

  always_comb begin
    cp_seen_d = cp_seen_q;
    lap_next  = lap_q;
    if (en) begin
      if (in_fl && cp_seen_q) begin
        cp_seen_d = 1'b0;
        if (lap_q < LapMax) lap_next = lap_q + 4'd1;
      end else if (in_cp) begin
        cp_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cp_seen_q <= 1'b0;
      lap_q     <= 4'd0;
    end else begin
      cp_seen_q <= cp_seen_d;
      lap_q     <= lap_next;
    end
  end

  assign lap = lap_q;

endmodule

// File: rtl/race_controller.sv
// Race sequencer: 60 Hz tick, menu/countdown/race/finish FSM, lap tracking for both cars,
// winner decision and the between-rounds reset pulse.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned LAPS          = 3,
  parameter logic [9:0]  FL_X0         = 10'd0,
  parameter logic [9:0]  FL_X1         = 10'd20,
  parameter logic [9:0]  FL_Y0         = 10'd100,
  parameter logic [9:0]  FL_Y1         = 10'd140,
  parameter logic [9:0]  CP_X0         = 10'd280,
  parameter logic [9:0]  CP_X1         = 10'd320,
  parameter logic [9:0]  CP_Y0         = 10'd100,
  parameter logic [9:0]  CP_Y1         = 10'd140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic [3:0]  p1_lap,
  output logic [3:0]  p2_lap,
  output logic [1:0]  winner,
  output logic [15:0] race_frames,
  output logic        round_rst
);

  localparam int unsigned TickMax = CLK_FREQ / 60;
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax + 1) : 1;
  localparam int unsigned SecW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [3:0]  LapMax  = 4'(LAPS);

  logic [TickW-1:0] tick_cnt_q;
  logic             game_tick;
  logic             start_prev_q, start_rise;
  race_state_e      state_q;
  logic [SecW-1:0]  sec_cnt_q;
  logic [1:0]       winner_q;
  logic [15:0]      frames_q;
  logic             round_rst_q;
  logic             track_en, track_clr;
  logic [3:0]       p1_lap_next, p2_lap_next;
  logic             p1_done, p2_done;

  // Same generator as the physics engines so both stay phase-aligned from reset.
  always_ff @(posedge clk) begin
    if (rst || (tick_cnt_q == TickW'(TickMax))) tick_cnt_q <= '0;
    else                                        tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign game_tick = (tick_cnt_q == '0);

  // Resets high so a button held through reset does not start a round.
  always_ff @(posedge clk) begin
    if (rst) start_prev_q <= 1'b1;
    else     start_prev_q <= start_btn;
  end

  assign start_rise = start_btn & ~start_prev_q;
  assign track_en   = game_tick && (state_q == ST_RACE);
  assign track_clr  = (state_q == ST_FINISH) && start_rise;

  lap_tracker #(
    .LAPS (LAPS),
    .FL_X0(FL_X0), .FL_X1(FL_X1), .FL_Y0(FL_Y0), .FL_Y1(FL_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p1 (
    .clk     (clk),
    .rst     (rst),
    .clr     (track_clr),
    .en      (track_en),
    .x       (p1_x),
    .y       (p1_y),
    .lap     (p1_lap),
    .lap_next(p1_lap_next)
  );

  lap_tracker #(
    .LAPS (LAPS),
    .FL_X0(FL_X0), .FL_X1(FL_X1), .FL_Y0(FL_Y0), .FL_Y1(FL_Y1),
    .CP_X0(CP_X0), .CP_X1(CP_X1), .CP_Y0(CP_Y0), .CP_Y1(CP_Y1)
  ) u_lap_p2 (
    .clk     (clk),
    .rst     (rst),
    .clr     (track_clr),
    .en      (track_en),
    .x       (p2_x),
    .y       (p2_y),
    .lap     (p2_lap),
    .lap_next(p2_lap_next)
  );

  assign p1_done = (p1_lap_next == LapMax);
  assign p2_done = (p2_lap_next == LapMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MENU;
      sec_cnt_q   <= '0;
      winner_q    <= WIN_NONE;
      frames_q    <= 16'd0;
      round_rst_q <= 1'b0;
    end else begin
      round_rst_q <= 1'b0;
      case (state_q)
        ST_MENU: begin
          if (start_rise) begin
            state_q   <= ST_CNT3;
            sec_cnt_q <= '0;
          end
        end
        ST_CNT3, ST_CNT2, ST_CNT1: begin
          if (game_tick) begin
            if (sec_cnt_q == SecW'(TICKS_PER_SEC - 1)) begin
              sec_cnt_q <= '0;
              state_q   <= next_count_state(state_q);
            end else begin
              sec_cnt_q <= sec_cnt_q + 1'b1;
            end
          end
        end
        ST_RACE: begin
          if (game_tick) begin
            if (frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
            // Winner is decided from the laps that this same edge commits.
            if (p1_done || p2_done) begin
              winner_q <= (p1_done && p2_done) ? WIN_TIE : (p1_done ? WIN_P1 : WIN_P2);
              state_q  <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          if (start_rise) begin
            state_q     <= ST_MENU;
            round_rst_q <= 1'b1;
            winner_q    <= WIN_NONE;
            frames_q    <= 16'd0;
            sec_cnt_q   <= '0;
          end
        end
        default: state_q <= ST_MENU;
      endcase
    end
  end

  assign state       = state_q;
  assign winner      = winner_q;
  assign race_frames = frames_q;
  assign round_rst   = round_rst_q;

endmodule

// File: tb/tb_race_controller.sv
// Randomised bench for race_controller: two instances (3 laps and 1 lap) share stimulus and are
// compared every clock against a tick-level reference of the race rules.
module tb_race_controller;

  localparam int unsigned ClkFreq    = 6000;
  localparam int unsigned Tps        = 2;
  localparam int unsigned TickPeriod = ClkFreq / 60 + 1;
  localparam int FlX0 = 0, FlX1 = 20, FlY0 = 100, FlY1 = 140;
  localparam int CpX0 = 280, CpX1 = 320, CpY0 = 100, CpY1 = 140;

  logic clk, rst, start_btn;
  logic [9:0] p1x, p1y, p2x, p2y;
  logic [2:0] st0, st1;
  logic [3:0] l1_0, l2_0, l1_1, l2_1;
  logic [1:0] w0, w1;
  logic [15:0] fr0, fr1;
  logic rr0, rr1;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned ticks_seen = 0;
  bit sprev = 1'b1;

  int unsigned m_st[2], m_l1[2], m_l2[2], m_c1[2], m_c2[2], m_win[2], m_fr[2], m_cd[2], m_rr[2];

  race_controller #(
    .CLK_FREQ(ClkFreq), .TICKS_PER_SEC(Tps), .LAPS(3),
    .FL_X0(10'd0), .FL_X1(10'd20), .FL_Y0(10'd100), .FL_Y1(10'd140),
    .CP_X0(10'd280), .CP_X1(10'd320), .CP_Y0(10'd100), .CP_Y1(10'd140)
  ) dut0 (
    .clk(clk), .rst(rst), .start_btn(start_btn),
    .p1_x(p1x), .p1_y(p1y), .p2_x(p2x), .p2_y(p2y),
    .state(st0), .p1_lap(l1_0), .p2_lap(l2_0), .winner(w0),
    .race_frames(fr0), .round_rst(rr0)
  );

  race_controller #(
    .CLK_FREQ(ClkFreq), .TICKS_PER_SEC(Tps), .LAPS(1),
    .FL_X0(10'd0), .FL_X1(10'd20), .FL_Y0(10'd100), .FL_Y1(10'd140),
    .CP_X0(10'd280), .CP_X1(10'd320), .CP_Y0(10'd100), .CP_Y1(10'd140)
  ) dut1 (
    .clk(clk), .rst(rst), .start_btn(start_btn),
    .p1_x(p1x), .p1_y(p1y), .p2_x(p2x), .p2_y(p2y),
    .state(st1), .p1_lap(l1_1), .p2_lap(l2_1), .winner(w1),
    .race_frames(fr1), .round_rst(rr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_fl(input int x, input int y);
    return x >= FlX0 && x <= FlX1 && y >= FlY0 && y <= FlY1;
  endfunction

  function automatic bit in_cp(input int x, input int y);
    return x >= CpX0 && x <= CpX1 && y >= CpY0 && y <= CpY1;
  endfunction

  // Reference of the race rules, advanced once per clock edge.
  task automatic model_edge(input bit rs, input bit tk, input bit rise);
    for (int d = 0; d < 2; d++) begin
      int unsigned lim;
      bit d1, d2;
      lim = (d == 0) ? 3 : 1;
      m_rr[d] = 0;
      if (rs) begin
        m_st[d] = 0; m_l1[d] = 0; m_l2[d] = 0; m_c1[d] = 0; m_c2[d] = 0;
        m_win[d] = 0; m_fr[d] = 0; m_cd[d] = 0;
      end else begin
        case (m_st[d])
          0: if (rise) begin m_st[d] = 1; m_cd[d] = 0; end
          1, 2, 3: if (tk) begin m_cd[d]++; m_st[d] = 1 + m_cd[d] / Tps; end
          4: if (tk) begin
            if (m_fr[d] < 65535) m_fr[d]++;
            if (in_fl(p1x, p1y) && m_c1[d] != 0) begin
              if (m_l1[d] < lim) m_l1[d]++;
              m_c1[d] = 0;
            end else if (in_cp(p1x, p1y)) m_c1[d] = 1;
            if (in_fl(p2x, p2y) && m_c2[d] != 0) begin
              if (m_l2[d] < lim) m_l2[d]++;
              m_c2[d] = 0;
            end else if (in_cp(p2x, p2y)) m_c2[d] = 1;
            d1 = (m_l1[d] == lim);
            d2 = (m_l2[d] == lim);
            if (d1 || d2) begin
              m_win[d] = (d1 && d2) ? 3 : (d1 ? 1 : 2);
              m_st[d] = 5;
            end
          end
          default: if (rise) begin
            m_st[d] = 0; m_rr[d] = 1; m_l1[d] = 0; m_l2[d] = 0; m_c1[d] = 0; m_c2[d] = 0;
            m_win[d] = 0; m_fr[d] = 0; m_cd[d] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    check_val("d0_state", 32'(st0), m_st[0]);
    check_val("d0_p1_lap", 32'(l1_0), m_l1[0]);
    check_val("d0_p2_lap", 32'(l2_0), m_l2[0]);
    check_val("d0_winner", 32'(w0), m_win[0]);
    check_val("d0_frames", 32'(fr0), m_fr[0]);
    check_val("d0_round_rst", 32'(rr0), m_rr[0]);
    check_val("d1_state", 32'(st1), m_st[1]);
    check_val("d1_p1_lap", 32'(l1_1), m_l1[1]);
    check_val("d1_p2_lap", 32'(l2_1), m_l2[1]);
    check_val("d1_winner", 32'(w1), m_win[1]);
    check_val("d1_frames", 32'(fr1), m_fr[1]);
    check_val("d1_round_rst", 32'(rr1), m_rr[1]);
  endtask

  task automatic step();
    bit rs, tk, rise;
    rs   = rst;
    tk   = (cyc % TickPeriod) == 0;
    rise = start_btn & ~sprev;
    @(posedge clk);
    if (rs) begin
      sprev = 1'b1;
      cyc   = 0;
    end else begin
      sprev = start_btn;
      cyc++;
      if (tk) ticks_seen++;
    end
    model_edge(rs, tk, rise);
    #1;
    check_all();
  endtask

  task automatic run_ticks(input int unsigned n);
    int unsigned target;
    target = ticks_seen + n;
    while (ticks_seen < target) step();
  endtask

  task automatic press();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic wait_race();
    for (int i = 0; i < 2000 && m_st[0] != 4; i++) step();
    check_val("wait_race", 32'(st0), 4);
  endtask

  function automatic logic [19:0] pt(input int i);
    case (i)
      0:  return {10'd10, 10'd120};
      1:  return {10'd20, 10'd120};
      2:  return {10'd0, 10'd100};
      3:  return {10'd20, 10'd140};
      4:  return {10'd21, 10'd120};
      5:  return {10'd10, 10'd99};
      6:  return {10'd10, 10'd141};
      7:  return {10'd300, 10'd120};
      8:  return {10'd280, 10'd100};
      9:  return {10'd320, 10'd140};
      10: return {10'd279, 10'd120};
      11: return {10'd321, 10'd120};
      12: return {10'd300, 10'd99};
      13: return {10'd300, 10'd141};
      default: return {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
    endcase
  endfunction

  initial begin
    logic [19:0] a;
    if (!(FlX1 < CpX0 || CpX1 < FlX0 || FlY1 < CpY0 || CpY1 < FlY0)) begin
      $display("FAIL box_overlap: finish line and checkpoint zones overlap");
      $fatal(1);
    end
    rst = 1'b1; start_btn = 1'b1;
    p1x = 10'd150; p1y = 10'd50; p2x = 10'd150; p2y = 10'd50;

    // Held button through reset must not start a round.
    step();
    rst = 1'b0;
    repeat (5) step();
    check_val("held_no_start", 32'(st0), 0);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    check_val("start_latency", 32'(st0), 1);

    // Countdown ignores further presses.
    for (int i = 0; i < 2000 && m_st[0] != 4; i++) begin
      start_btn = ($urandom_range(0, 3) == 0);
      step();
    end
    start_btn = 1'b0;
    check_val("countdown_done", 32'(st0), 4);

    // P1 lap sequence; P2 parks on the line without a checkpoint visit.
    p2x = 10'd10; p2y = 10'd120;
    p1x = 10'd10; p1y = 10'd120;  run_ticks(1);
    check_val("p1_fl_first", 32'(l1_0), 0);
    p1x = 10'd300;                run_ticks(1);
    check_val("p1_after_cp", 32'(l1_0), 0);
    p1x = 10'd10;                 run_ticks(1);
    check_val("p1_lap_one", 32'(l1_0), 1);
    check_val("d1_p1_win", 32'(w1), 1);
    run_ticks(5);
    check_val("p1_hold_fl", 32'(l1_0), 1);
    check_val("p2_no_cp", 32'(l2_0), 0);

    // Finish-line right edge: x=21 outside, x=20 inside.
    p2x = 10'd300; run_ticks(1);
    p2x = 10'd21;  run_ticks(1);
    check_val("p2_x21_out", 32'(l2_0), 0);
    p2x = 10'd20;  run_ticks(1);
    check_val("p2_x20_in", 32'(l2_0), 1);

    for (int k = 0; k < 2; k++) begin
      p1x = 10'd300; run_ticks(1);
      p1x = 10'd10;  run_ticks(1);
    end
    check_val("d0_p1_win", 32'(w0), 1);
    check_val("d0_finish", 32'(st0), 5);

    start_btn = 1'b1;
    step();
    check_val("rr_pulse", 32'(rr0), 1);
    start_btn = 1'b0;
    step();
    check_val("rr_one_clk", 32'(rr0), 0);

    // Simultaneous lap completions: tie on the 1-lap instance, then on the 3-lap one.
    p1x = 10'd150; p2x = 10'd150;
    press();
    wait_race();
    for (int k = 0; k < 3; k++) begin
      p1x = 10'd300; p2x = 10'd300; run_ticks(1);
      p1x = 10'd10;  p2x = 10'd10;  run_ticks(1);
      if (k == 0) begin
        check_val("tie_winner", 32'(w1), 3);
        check_val("tie_state", 32'(st1), 5);
      end
    end
    check_val("d0_tie", 32'(w0), 3);
    run_ticks(3);
    press();
    check_val("menu_after_rr", 32'(st0), 0);

    // Reset in the middle of a race.
    press();
    wait_race();
    p1x = 10'd300; run_ticks(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_mid_state", 32'(st0), 0);
    check_val("rst_mid_frames", 32'(fr0), 0);
    step();

    // Random play across rounds, with occasional presses and resets.
    for (int t = 0; t < 150; t++) begin
      a = pt($urandom_range(0, 15));
      p1x = a[19:10]; p1y = a[9:0];
      a = pt($urandom_range(0, 15));
      p2x = a[19:10]; p2y = a[9:0];
      if ($urandom_range(0, 5) == 0) press();
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run_ticks(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/race_controller.md
# race_controller

Top-level race sequencer for the two-player racer. It generates the 3-bit game `state` consumed by both physics engines: menu, a 3-2-1 countdown, racing (`3'd4`), and finish. During the race it watches each car's `pos_x`/`pos_y`, counts laps via a checkpoint-then-finish-line rule, and declares the winner. It also emits a one-cycle `round_rst` pulse so the top level can re-seat the physics engines between rounds.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz; sets the 60 Hz game tick.
- `TICKS_PER_SEC`, 60, game ticks per countdown step.
- `LAPS`, 3, laps to win (1..15).
- `FL_X0`/`FL_X1`/`FL_Y0`/`FL_Y1`, 0/20/100/140, finish-line zone, inclusive bounds, 10-bit.
- `CP_X0`/`CP_X1`/`CP_Y0`/`CP_Y1`, 280/320/100/140, checkpoint zone, inclusive bounds, 10-bit.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_btn`  in  1  debounced start level; acted on at its rising edge.
- `p1_x`, `p1_y`  in  10 each  player-1 car centre.
- `p2_x`, `p2_y`  in  10 each  player-2 car centre.
- `state`  out  3  0 MENU, 1 CNT3, 2 CNT2, 3 CNT1, 4 RACE, 5 FINISH; registered.
- `p1_lap`, `p2_lap`  out  4 each  completed laps; registered.
- `winner`  out  2  0 none, 1 P1, 2 P2, 3 tie; registered.
- `race_frames`  out  16  ticks elapsed in RACE; saturates at 16'hFFFF.
- `round_rst`  out  1  one-cycle pulse on FINISH→MENU.

## Operation
- Tick generator:
  - `tick_cnt` counts 0..CLK_FREQ/60, then wraps to 0.
  - `game_tick` is high when `tick_cnt == 0`, so the period is CLK_FREQ/60+1 clocks.
  - This is identical to the physics engines' generator, so the two stay phase-aligned from the same reset.
- Start edge:
  - `start_prev` is registered each clock.
  - `start_rise = start_btn & ~start_prev`.
  - `start_prev` resets to 1, so a button held through reset does not fire.
- FSM (advances on the clock, not on the tick, except where noted):
  - MENU: `start_rise` → CNT3. On entry, `sec_cnt` is cleared.
  - CNT3/CNT2/CNT1: `sec_cnt` increments on each `game_tick`. When it reaches TICKS_PER_SEC-1 on a tick, `sec_cnt` is cleared and the FSM goes to the next state. CNT1 is followed by RACE.
  - RACE: exits to FINISH when `winner` becomes non-zero.
  - FINISH: `start_rise` → MENU and assert `round_rst` for that one clock. Laps, winner, `race_frames`, checkpoint flags and `sec_cnt` all clear on the same edge.
  - `start_rise` is ignored in CNT3, CNT2, CNT1 and RACE.
- Lap tracking (per player; evaluated only on `game_tick` while `state == RACE`):
  - `in_cp` = position inside the CP box; `in_fl` = position inside the FL box. Both are combinational with inclusive compares.
  - If `in_cp`, set `cp_seen`.
  - If `in_fl & cp_seen`, do lap+1 and clear `cp_seen`. Set and clear in the same tick cannot occur because the boxes must not overlap; the parameter check lives in the bench.
  - The lap counter saturates at LAPS.
  - A car starting inside FL has `cp_seen=0`, so no lap is credited.
- Winner:
  - Evaluated from the next-lap values on the same tick edge.
  - Only P1 reaches LAPS → 1. Only P2 → 2. Both on the same tick → 3.
  - `winner` and `state`=FINISH update on the same edge as the final lap increment.
- `race_frames` increments on each `game_tick` in RACE and freezes in FINISH.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - `state`=0, `p1_lap`=`p2_lap`=0, `winner`=0, `race_frames`=0, `round_rst`=0.
  - `tick_cnt`=0, so the first tick occurs in the first cycle after reset.
  - `sec_cnt`=0, `cp_seen`=0, `start_prev`=1.
- `start_rise` at edge N puts `state`=1 after edge N (one-clock latency).
- Countdown: each count state spans exactly TICKS_PER_SEC ticks.
- Lap, winner and `state` changes are visible one clock after the qualifying `game_tick` cycle.
- Reset mid-operation overrides everything, including the FINISH→MENU pulse.
- All outputs are registered; the position inputs have no combinational path to any output.

## Structure
- Shared package `race_pkg`:
  - State localparams `ST_MENU`..`ST_FINISH` (3'd0..3'd5), which the physics engines also use for `ST_RACE`=3'd4.
  - Winner codes `WIN_NONE`/`WIN_P1`/`WIN_P2`/`WIN_TIE`.
- Sub-module `lap_tracker`, instantiated once per player.
  - Ports: `clk`, `rst`, `clr`, `en` (= `game_tick & RACE`), `x`, `y`.
  - Outputs: `lap` [3:0] and `lap_next` [3:0].
  - It holds the zone compares, `cp_seen` and the saturating lap counter.

## Test plan
Run all scenarios with `CLK_FREQ`=6000 (tick every 101 clocks) and `TICKS_PER_SEC`=2.
- Reset with `start_btn` held high, then keep it high → `state` stays 0. Release and press again → `state`=1 one clock later.
- From the start press → CNT3, CNT2 and CNT1 each last 2 ticks; `state`=4 after 6 ticks. `start_btn` pulses during the countdown have no effect.
- P1 positions FL(10,120), then CP(300,120), then FL(10,120) on successive ticks → `p1_lap` reads 0, 0, 1. Holding P1 at FL(10,120) for 5 further ticks → lap stays 1.
- P2 enters FL (10,120) without first visiting CP → `p2_lap` stays 0. A point at x=21 counts as outside FL; x=20 counts as inside.
- `LAPS`=1, both cars complete a lap on the same tick → `winner`=3 and `state`=5 on the same edge; `race_frames` then freezes.
- From FINISH, press start → `round_rst`=1 for exactly one clock and `state`=0 with laps, winner and frames at 0. Separately, assert `rst` mid-RACE → all outputs at their reset values on the next edge.
